// File: rtl/mux_scan_sel_if.sv
// Bus bundle for mux_scan_sel: packed input channels, start controls and the
// valid/ready output word. chan_mask exists only when CHANNELS_MASK_EN is defined.
interface mux_scan_sel_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8
);
  localparam int SEL_W = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]          sel;
  logic                      mode;
  logic                      start;
`ifdef CHANNELS_MASK_EN
  logic [CHANNELS-1:0]       chan_mask;
`endif
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;
  logic                      out_valid;
  logic                      out_ready;
  logic                      busy;

  modport slave (
    input  in_data, sel, mode, start, out_ready,
`ifdef CHANNELS_MASK_EN
    input  chan_mask,
`endif
    output out_data, out_chan, out_valid, busy
  );

  modport master (
    output in_data, sel, mode, start, out_ready,
`ifdef CHANNELS_MASK_EN
    output chan_mask,
`endif
    input  out_data, out_chan, out_valid, busy
  );
endinterface

// File: rtl/mux_scan_sel.sv
// Channel selector that presents one channel (manual) or walks all eligible
// channels in ascending order (scan) over a valid/ready output. Optional macro: CHANNELS_MASK_EN.
module mux_scan_sel #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_scan_sel_if.slave bus
);
  localparam int SEL_W = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    data_q;
  logic [SEL_W-1:0]    chan_q;
  logic                scan_q, scan_d;

  logic [CHANNELS-1:0] start_mask;  // eligibility captured at a scan start
  logic [CHANNELS-1:0] cur_mask;    // eligibility for the scan in progress
  logic                load;
  logic [SEL_W-1:0]    load_idx;
  logic [WIDTH-1:0]    load_data;
  logic [SEL_W-1:0]    first_idx, next_idx;
  logic                has_next;

`ifdef CHANNELS_MASK_EN
  logic [CHANNELS-1:0] mask_q, mask_d;
  assign start_mask = bus.chan_mask;
  assign cur_mask   = mask_q;
`else
  assign start_mask = '1;
  assign cur_mask   = '1;
`endif

  // Downward loops let the lowest qualifying index win.
  always_comb begin
    first_idx = '0;
    next_idx  = '0;
    has_next  = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (start_mask[i]) first_idx = SEL_W'(i);
      if (cur_mask[i] && (i > int'(chan_q))) begin
        next_idx = SEL_W'(i);
        has_next = 1'b1;
      end
    end
  end

  // Indices at or above CHANNELS match no channel and yield zero data.
  always_comb begin
    load_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(load_idx) == i) load_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d  = state_q;
    scan_d   = scan_q;
    load     = 1'b0;
    load_idx = '0;
`ifdef CHANNELS_MASK_EN
    mask_d   = mask_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (!bus.mode) begin
            load     = 1'b1;
            load_idx = bus.sel;
            scan_d   = 1'b0;
            state_d  = PRESENT;
          end else if (|start_mask) begin
            load     = 1'b1;
            load_idx = first_idx;
            scan_d   = 1'b1;
            state_d  = PRESENT;
`ifdef CHANNELS_MASK_EN
            mask_d   = start_mask;
`endif
          end
        end
      end
      PRESENT: begin
        if (bus.out_ready) begin
          if (scan_q && has_next) begin
            load     = 1'b1;
            load_idx = next_idx;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the output word is reset too because it is
  // observable as zero straight after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      chan_q  <= '0;
      scan_q  <= 1'b0;
`ifdef CHANNELS_MASK_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      scan_q  <= scan_d;
`ifdef CHANNELS_MASK_EN
      mask_q  <= mask_d;
`endif
      if (load) begin
        data_q <= load_data;
        chan_q <= load_idx;
      end
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_chan  = chan_q;
  assign bus.out_valid = (state_q == PRESENT);
  assign bus.busy      = (state_q == PRESENT);
endmodule

// File: tb/tb_mux_scan_sel.sv
// Directed bench for mux_scan_sel: an 8-channel and a 6-channel instance
// exercised with hand-computed expectations.
module tb_mux_scan_sel;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux_scan_sel_if #(.WIDTH(8), .CHANNELS(8)) b8 ();
  mux_scan_sel_if #(.WIDTH(8), .CHANNELS(6)) b6 ();

  mux_scan_sel #(.WIDTH(8), .CHANNELS(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
  mux_scan_sel #(.WIDTH(8), .CHANNELS(6)) dut6 (.clk(clk), .rst_n(rst_n), .bus(b6.slave));

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] DATA8 = 64'h0706050403020100;
  localparam logic [47:0] DATA6 = 48'h050403020100;

  initial begin
    rst_n = 1'b0;
    b8.in_data = DATA8; b8.sel = '0; b8.mode = 1'b0; b8.start = 1'b0; b8.out_ready = 1'b0;
    b6.in_data = DATA6; b6.sel = '0; b6.mode = 1'b0; b6.start = 1'b0; b6.out_ready = 1'b0;
`ifdef CHANNELS_MASK_EN
    b8.chan_mask = '1;
    b6.chan_mask = '1;
`endif
    tick; tick;
    check("rst_valid", 64'(b8.out_valid), 64'd0);
    check("rst_busy",  64'(b8.busy),      64'd0);
    check("rst_data",  64'(b8.out_data),  64'd0);
    check("rst_chan",  64'(b8.out_chan),  64'd0);

    // Manual start on the very first edge with reset released.
    rst_n = 1'b1; b8.sel = 3'd5; b8.mode = 1'b0; b8.start = 1'b1; b8.out_ready = 1'b1;
    tick;
    check("man_valid", 64'(b8.out_valid), 64'd1);
    check("man_data",  64'(b8.out_data),  64'h05);
    check("man_chan",  64'(b8.out_chan),  64'd5);
    check("man_busy",  64'(b8.busy),      64'd1);
    b8.start = 1'b0;
    tick;
    check("man_done_valid", 64'(b8.out_valid), 64'd0);
    check("man_done_busy",  64'(b8.busy),      64'd0);
    tick;
    check("idle_ready_noeffect", 64'(b8.out_valid), 64'd0);

    // Full scan, no bubbles; start/mode/sel keep changing while busy.
    b8.mode = 1'b1; b8.start = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick;
      if (k == 0) begin b8.mode = 1'b0; b8.sel = 3'd3; end
      check($sformatf("scan_data%0d", k),  64'(b8.out_data),  64'(k));
      check($sformatf("scan_chan%0d", k),  64'(b8.out_chan),  64'(k));
      check($sformatf("scan_valid%0d", k), 64'(b8.out_valid), 64'd1);
    end
    tick;  // completing handshake with start still high must not restart
    check("scan_end_valid", 64'(b8.out_valid), 64'd0);
    check("scan_end_busy",  64'(b8.busy),      64'd0);
    b8.start = 1'b0;
    tick;
    check("scan_no_wrap", 64'(b8.out_valid), 64'd0);

    // Stall on channel 2 while in_data churns.
    b8.mode = 1'b1; b8.start = 1'b1;
    tick; b8.start = 1'b0;
    tick; tick;
    check("stall_reach_chan", 64'(b8.out_chan), 64'd2);
    b8.out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      b8.in_data = {8{8'(8'hA0 + j)}};
      tick;
      check($sformatf("stall_data%0d", j),  64'(b8.out_data),  64'h02);
      check($sformatf("stall_chan%0d", j),  64'(b8.out_chan),  64'd2);
      check($sformatf("stall_valid%0d", j), 64'(b8.out_valid), 64'd1);
    end
    b8.in_data = DATA8; b8.out_ready = 1'b1;
    tick;
    check("after_stall_data", 64'(b8.out_data), 64'h03);
    tick;
    check("pre_rst_chan", 64'(b8.out_chan), 64'd4);

    // Mid-scan reset at channel 4.
    rst_n = 1'b0;
    tick;
    check("midrst_valid", 64'(b8.out_valid), 64'd0);
    check("midrst_busy",  64'(b8.busy),      64'd0);
    check("midrst_data",  64'(b8.out_data),  64'd0);
    check("midrst_chan",  64'(b8.out_chan),  64'd0);
    rst_n = 1'b1;
    tick;
    check("midrst_stay_idle", 64'(b8.out_valid), 64'd0);

    // Six channels: out-of-range manual select, then a full scan ending at 5.
    b6.sel = 3'd7; b6.mode = 1'b0; b6.start = 1'b1; b6.out_ready = 1'b1;
    tick;
    check("oor_valid", 64'(b6.out_valid), 64'd1);
    check("oor_data",  64'(b6.out_data),  64'd0);
    check("oor_chan",  64'(b6.out_chan),  64'd7);
    b6.start = 1'b0;
    tick;
    check("oor_done", 64'(b6.out_valid), 64'd0);

    b6.mode = 1'b1; b6.start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick;
      b6.start = 1'b0;
      check($sformatf("scan6_chan%0d", k), 64'(b6.out_chan), 64'(k));
      check($sformatf("scan6_data%0d", k), 64'(b6.out_data), 64'(k));
    end
    tick;
    check("scan6_end", 64'(b6.out_valid), 64'd0);

`ifdef CHANNELS_MASK_EN
    // Masked scan visits 0, 2, 5 only; an empty mask is ignored.
    b6.chan_mask = 6'b100101; b6.mode = 1'b1; b6.start = 1'b1;
    tick; b6.start = 1'b0;
    check("mask_c0", 64'(b6.out_chan), 64'd0);
    tick;
    check("mask_c2", 64'(b6.out_chan), 64'd2);
    check("mask_d2", 64'(b6.out_data), 64'h02);
    tick;
    check("mask_c5", 64'(b6.out_chan), 64'd5);
    tick;
    check("mask_end", 64'(b6.out_valid), 64'd0);
    b6.chan_mask = '0; b6.start = 1'b1;
    tick; b6.start = 1'b0;
    check("mask_zero_valid", 64'(b6.out_valid), 64'd0);
    check("mask_zero_busy",  64'(b6.busy),      64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
